scr1_dmem_lane_bridge: RTL and testbench
========================================

# scr1_dmem_lane_bridge

Byte-lane bridge between the LSU data-memory port and a word-organised SRAM-style data bus (TCM or interconnect slave). Accepts one LSU request at a time and converts byte/halfword/word accesses into a word-aligned address with byte enables and lane-replicated write data. On loads it shifts the returned word so the addressed data lands in bits [15:0]/[7:0], as the LSU sign/zero-extender expects. Adds its own misalignment check and a response timeout, so the LSU always receives exactly one RDY_OK or RDY_ER per accepted request.

## Interface
- TIMEOUT, 255: cycles a transaction may spend in REQ+RESP before an RDY_ER completion; 0 disables the timeout. Range 0..255 (8-bit counter).
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lsu2dmem_req  in  1  LSU request valid
- lsu2dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR
- lsu2dmem_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD
- lsu2dmem_addr  in  `SCR1_DMEM_AWIDTH (32)  byte address
- lsu2dmem_wdata  in  `SCR1_DMEM_DWIDTH (32)  store data, right-justified
- dmem2lsu_req_ack  out  1  request accepted
- dmem2lsu_rdata  out  32  load data, right-justified
- dmem2lsu_resp  out  type_scr1_mem_resp_e  NOTRDY/RDY_OK/RDY_ER, one-cycle pulse
- mem_req  out  1  bus request, held until mem_gnt
- mem_we  out  1  1 = write
- mem_be  out  4  byte enables
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_wdata  out  32  lane-replicated write data
- mem_gnt  in  1  bus accepted mem_req this cycle
- mem_rvalid  in  1  completion for a granted request (reads and writes)
- mem_rdata  in  32  read word
- mem_err  in  1  error qualifier, valid with mem_rvalid

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- IDLE: dmem2lsu_req_ack = 1. When lsu2dmem_req = 1, register cmd, width, addr[1:0], word address, be and formatted wdata.
  - If the access is misaligned (HWORD with addr[0] = 1; WORD with addr[1:0] ≠ 0): go to DONE with err_flag = 1. No bus access is made.
  - Otherwise: go to REQ and clear the timeout counter.
- REQ: mem_req = 1, and all mem_* outputs are stable from registers.
  - On mem_gnt: go to RESP.
- RESP: mem_req = 0.
  - On mem_rvalid: go to DONE with err_flag = mem_err, and register aligned read data.
- DONE: dmem2lsu_resp = err_flag ? RDY_ER : RDY_OK for exactly one cycle, then go to IDLE. dmem2lsu_req_ack = 0.
- dmem2lsu_resp = NOTRDY in every state except DONE.
- Timeout: the counter increments every cycle spent in REQ or RESP.
  - When it reaches TIMEOUT-1 with no gnt (in REQ) or no rvalid (in RESP) that cycle: go to DONE with err_flag = 1.
  - A gnt/rvalid event in the same cycle takes priority over the timeout.
  - A timeout in REQ drops mem_req; the bus treats this as a cancel.
- Stray mem_rvalid/mem_gnt outside the RESP/REQ states is ignored.
- Write formatting:
  - BYTE: wdata = {4{wdata[7:0]}}, be = 4'b0001 << addr[1:0].
  - HWORD: wdata = {2{wdata[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - WORD: wdata unchanged, be = 4'b1111.
- Reads drive be with the same encoding as writes.
- Read alignment: rdata = mem_rdata >> (8·addr[1:0]), zero-filled. Writes leave dmem2lsu_rdata unchanged.
- mem_addr = {addr[31:2], 2'b00}.

## Timing
- Reset values:
  - mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0.
  - dmem2lsu_rdata = 0, dmem2lsu_resp = NOTRDY.
  - dmem2lsu_req_ack = 1 (IDLE).
- Cycle 0: req & ack. Cycle 1: mem_req. The earliest gnt is cycle 1; rvalid comes no earlier than the cycle after gnt. DONE/resp is on the cycle after rvalid.
  - Minimum latency from ack to resp is 3 cycles.
- Misaligned request: resp = RDY_ER in cycle 1.
- resp is never asserted in the same cycle as req_ack, and there is never more than one outstanding transaction.
- Reset asserted mid-transaction: all state and outputs return to reset values immediately. No resp is issued for the aborted request.

## Test plan
- SB addr 0x0000_1003, wdata 0x0000_00A5:
  - Expect mem_addr = 0x1000, be = 4'b1000, mem_wdata = 0xA5A5_A5A5, mem_we = 1.
  - With gnt in cycle 1 and rvalid in cycle 2: RDY_OK in cycle 3.
- LH addr 0x2002, mem_rdata 0xBEEF_1234 -> be = 4'b1100, dmem2lsu_rdata = 0x0000_BEEF, RDY_OK.
- LW addr 0x3001 -> mem_req stays 0 throughout; RDY_ER in cycle 1; back in IDLE (ack = 1) in cycle 2.
- TIMEOUT = 4, mem_gnt held 0 -> mem_req high in cycles 1–4, RDY_ER in cycle 5. A gnt arriving in cycle 4 instead gives a normal completion.
- LW addr 0x4000 with rvalid & mem_err = 1 -> RDY_ER. Back-to-back requests are accepted in the first IDLE cycle after DONE.
- Assert rst_n low during RESP -> all outputs reach reset values, no resp pulse, next request completes normally.

Source files
------------

// File: rtl/scr1_dmem_lane_bridge.sv
// LSU-to-word-bus bridge: turns byte/halfword/word accesses into word-aligned
// requests with byte enables, and right-justifies load data for the LSU.
package scr1_memif_pkg;
    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_lane_bridge
    import scr1_memif_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        lsu2dmem_req,
    input  type_scr1_mem_cmd_e          lsu2dmem_cmd,
    input  type_scr1_mem_width_e        lsu2dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] lsu2dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] lsu2dmem_wdata,
    output logic                        dmem2lsu_req_ack,
    output logic [31:0]                 dmem2lsu_rdata,
    output type_scr1_mem_resp_e         dmem2lsu_resp,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [3:0]                  mem_be,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10,
        DONE = 2'b11
    } state_e;

    // Timeout fires once the counter has reached TIMEOUT-1; 0 disables it.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam bit         TO_EN   = (TIMEOUT != 0);

    state_e             state, state_next;
    logic               err_flag, err_next;
    logic [7:0]         cnt, cnt_next;
    type_scr1_mem_cmd_e cmd_r;
    logic [1:0]         off_r;

    logic               accept;
    logic               misaligned;
    logic [3:0]         be_fmt;
    logic [31:0]        wdata_fmt;
    logic               timeout_hit;

    assign accept      = (state == IDLE) && lsu2dmem_req;
    assign timeout_hit = TO_EN && (cnt >= TO_LAST);

    always_comb begin
        be_fmt     = 4'b1111;
        wdata_fmt  = lsu2dmem_wdata;
        misaligned = 1'b0;
        case (lsu2dmem_width)
            SCR1_MEM_WIDTH_BYTE: begin
                be_fmt    = 4'b0001 << lsu2dmem_addr[1:0];
                wdata_fmt = {4{lsu2dmem_wdata[7:0]}};
            end
            SCR1_MEM_WIDTH_HWORD: begin
                be_fmt     = lsu2dmem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_fmt  = {2{lsu2dmem_wdata[15:0]}};
                misaligned = lsu2dmem_addr[0];
            end
            SCR1_MEM_WIDTH_WORD: begin
                misaligned = |lsu2dmem_addr[1:0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        err_next   = err_flag;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (lsu2dmem_req) begin
                    if (misaligned) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else begin
                        state_next = REQ;
                        err_next   = 1'b0;
                        cnt_next   = 8'd0;
                    end
                end
            end
            REQ: begin
                // A grant in the timeout cycle wins over the timeout.
                if (mem_gnt) begin
                    state_next = RESP;
                end else if (timeout_hit) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
                if (cnt != 8'hFF) cnt_next = cnt + 8'd1;
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_next = DONE;
                    err_next   = mem_err;
                end else if (timeout_hit) begin
                    state_next = DONE;
                    err_next   = 1'b1;
                end
                if (cnt != 8'hFF) cnt_next = cnt + 8'd1;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            err_flag       <= 1'b0;
            cnt            <= 8'd0;
            cmd_r          <= SCR1_MEM_CMD_RD;
            off_r          <= 2'b00;
            mem_we         <= 1'b0;
            mem_be         <= 4'b0000;
            mem_addr       <= 32'd0;
            mem_wdata      <= 32'd0;
            dmem2lsu_rdata <= 32'd0;
        end else begin
            state    <= state_next;
            err_flag <= err_next;
            cnt      <= cnt_next;
            if (accept) begin
                cmd_r     <= lsu2dmem_cmd;
                off_r     <= lsu2dmem_addr[1:0];
                mem_we    <= (lsu2dmem_cmd == SCR1_MEM_CMD_WR);
                mem_be    <= be_fmt;
                mem_addr  <= {lsu2dmem_addr[31:2], 2'b00};
                mem_wdata <= wdata_fmt;
            end
            if ((state == RESP) && mem_rvalid && (cmd_r == SCR1_MEM_CMD_RD)) begin
                dmem2lsu_rdata <= mem_rdata >> {off_r, 3'b000};
            end
        end
    end

    assign mem_req          = (state == REQ);
    assign dmem2lsu_req_ack = (state == IDLE);
    assign dmem2lsu_resp    = (state != DONE) ? SCR1_MEM_RESP_NOTRDY :
                              err_flag        ? SCR1_MEM_RESP_RDY_ER :
                                                SCR1_MEM_RESP_RDY_OK;

endmodule

// File: tb/tb_scr1_dmem_lane_bridge.sv
// Directed bench for scr1_dmem_lane_bridge: expected bus requests and LSU
// responses are queued at issue time and popped by independent monitors.
module tb_scr1_dmem_lane_bridge;
    import scr1_memif_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 lsu2dmem_req = 1'b0;
    type_scr1_mem_cmd_e   lsu2dmem_cmd = SCR1_MEM_CMD_RD;
    type_scr1_mem_width_e lsu2dmem_width = SCR1_MEM_WIDTH_WORD;
    logic [31:0]          lsu2dmem_addr = 32'd0;
    logic [31:0]          lsu2dmem_wdata = 32'd0;
    logic                 dmem2lsu_req_ack;
    logic [31:0]          dmem2lsu_rdata;
    type_scr1_mem_resp_e  dmem2lsu_resp;
    logic                 mem_req;
    logic                 mem_we;
    logic [3:0]           mem_be;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_gnt = 1'b0;
    logic                 mem_rvalid = 1'b0;
    logic [31:0]          mem_rdata = 32'd0;
    logic                 mem_err = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // {resp[1:0], rdata[31:0], cycle[31:0]}
    logic [65:0] exp_q[$];
    // {we, be[3:0], addr[31:0], wdata[31:0]}
    logic [68:0] exp_bus_q[$];

    scr1_dmem_lane_bridge #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lsu2dmem_req     (lsu2dmem_req),
        .lsu2dmem_cmd     (lsu2dmem_cmd),
        .lsu2dmem_width   (lsu2dmem_width),
        .lsu2dmem_addr    (lsu2dmem_addr),
        .lsu2dmem_wdata   (lsu2dmem_wdata),
        .dmem2lsu_req_ack (dmem2lsu_req_ack),
        .dmem2lsu_rdata   (dmem2lsu_rdata),
        .dmem2lsu_resp    (dmem2lsu_resp),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_be           (mem_be),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .mem_err          (mem_err)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_bus(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        exp_bus_q.push_back({we, be, a, d});
    endtask

    task automatic push_resp(input type_scr1_mem_resp_e r, input logic [31:0] d, input int c);
        exp_q.push_back({r, d, 32'(c)});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_req"},   69'(mem_req),          69'(0));
        check({tag, "_mem_we"},    69'(mem_we),           69'(0));
        check({tag, "_mem_be"},    69'(mem_be),           69'(0));
        check({tag, "_mem_addr"},  69'(mem_addr),         69'(0));
        check({tag, "_mem_wdata"}, 69'(mem_wdata),        69'(0));
        check({tag, "_rdata"},     69'(dmem2lsu_rdata),   69'(0));
        check({tag, "_resp"},      69'(dmem2lsu_resp),    69'(SCR1_MEM_RESP_NOTRDY));
        check({tag, "_ack"},       69'(dmem2lsu_req_ack), 69'(1));
    endtask

    // Call at posedge+1; returns at posedge+1 of cycle 1 with c0 = cycle of acceptance.
    task automatic issue(input logic wr, input type_scr1_mem_width_e w,
                         input logic [31:0] a, input logic [31:0] d, output int c0);
        lsu2dmem_req   = 1'b1;
        lsu2dmem_cmd   = wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        lsu2dmem_width = w;
        lsu2dmem_addr  = a;
        lsu2dmem_wdata = d;
        c0 = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dmem2lsu_req_ack) begin
                c0 = cyc;
                break;
            end
        end
        if (c0 < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_wait actual=no_ack required=ack addr=0x%0h", a);
        end
        @(posedge clk);
        #1;
        lsu2dmem_req = 1'b0;
    endtask

    // Drives gnt in cycle g and rvalid in cycle r (0 = never) for n cycles.
    task automatic bus_phase(input int g, input int r, input int n, input logic [31:0] rd, input logic e);
        for (int c = 1; c <= n; c++) begin
            mem_gnt    = (c == g);
            mem_rvalid = (c == r);
            mem_rdata  = rd;
            mem_err    = e;
            @(posedge clk);
            #1;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
    endtask

    // response monitor
    always @(negedge clk) begin : resp_mon
        logic [65:0] e;
        if (dmem2lsu_resp !== SCR1_MEM_RESP_NOTRDY) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%0d required=none cyc=%0d", dmem2lsu_resp, cyc);
            end else begin
                e = exp_q.pop_front();
                check("resp_code",  69'(dmem2lsu_resp),    69'(e[65:64]));
                check("resp_rdata", 69'(dmem2lsu_rdata),   69'(e[63:32]));
                check("resp_cycle", 69'(cyc),              69'(e[31:0]));
                check("resp_ack",   69'(dmem2lsu_req_ack), 69'(0));
            end
        end
    end

    // bus request monitor
    always @(negedge clk) begin : bus_mon
        if (rst_n && mem_req && mem_gnt) begin
            if (exp_bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bus_req actual=0x%0h required=none", mem_addr);
            end else begin
                check("bus_req", {mem_we, mem_be, mem_addr, mem_wdata}, exp_bus_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int prev;

        // reset
        @(negedge clk);
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SB 0x1003
        issue(1'b1, SCR1_MEM_WIDTH_BYTE, 32'h0000_1003, 32'h0000_00A5, c0);
        push_bus(1'b1, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5);
        push_resp(SCR1_MEM_RESP_RDY_OK, 32'h0, c0 + 3);
        bus_phase(1, 2, 2, 32'h0, 1'b0);
        prev = c0;

        // LH 0x2002, issued during DONE: accepted in the first IDLE cycle
        issue(1'b0, SCR1_MEM_WIDTH_HWORD, 32'h0000_2002, 32'h0, c0);
        check("b2b_accept_1", 69'(c0), 69'(prev + 4));
        push_bus(1'b0, 4'b1100, 32'h0000_2000, 32'h0);
        push_resp(SCR1_MEM_RESP_RDY_OK, 32'h0000_BEEF, c0 + 3);
        bus_phase(1, 2, 2, 32'hBEEF_1234, 1'b0);

        // LW 0x3001 misaligned
        issue(1'b0, SCR1_MEM_WIDTH_WORD, 32'h0000_3001, 32'h0, c0);
        push_resp(SCR1_MEM_RESP_RDY_ER, 32'h0000_BEEF, c0 + 1);
        @(negedge clk);
        check("misal_no_req_c1", 69'(mem_req), 69'(0));
        @(negedge clk);
        check("misal_no_req_c2", 69'(mem_req), 69'(0));
        check("misal_idle_c2", 69'(dmem2lsu_req_ack), 69'(1));
        @(posedge clk);
        #1;

        // LB 0x5001 with no grant: timeout
        issue(1'b0, SCR1_MEM_WIDTH_BYTE, 32'h0000_5001, 32'h0, c0);
        push_resp(SCR1_MEM_RESP_RDY_ER, 32'h0000_BEEF, c0 + 5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("timeout_mem_req_c%0d", k), 69'(mem_req), 69'(k <= 4));
        end
        @(posedge clk);
        #1;

        // SH 0x6002 with grant in the timeout cycle
        issue(1'b1, SCR1_MEM_WIDTH_HWORD, 32'h0000_6002, 32'h1234_5678, c0);
        push_bus(1'b1, 4'b1100, 32'h0000_6000, 32'h5678_5678);
        push_resp(SCR1_MEM_RESP_RDY_OK, 32'h0000_BEEF, c0 + 6);
        bus_phase(4, 5, 5, 32'h0, 1'b0);

        // LW 0x4000 with bus error
        issue(1'b0, SCR1_MEM_WIDTH_WORD, 32'h0000_4000, 32'h0, c0);
        push_bus(1'b0, 4'b1111, 32'h0000_4000, 32'h0);
        push_resp(SCR1_MEM_RESP_RDY_ER, 32'hDEAD_BEEF, c0 + 3);
        bus_phase(1, 2, 2, 32'hDEAD_BEEF, 1'b1);
        prev = c0;

        // LB 0x7001 back-to-back, late rvalid
        issue(1'b0, SCR1_MEM_WIDTH_BYTE, 32'h0000_7001, 32'h0, c0);
        check("b2b_accept_2", 69'(c0), 69'(prev + 4));
        push_bus(1'b0, 4'b0010, 32'h0000_7000, 32'h0);
        push_resp(SCR1_MEM_RESP_RDY_OK, 32'h0011_2233, c0 + 4);
        bus_phase(1, 3, 3, 32'h1122_3344, 1'b0);

        // SW 0x8000, late grant and rvalid
        issue(1'b1, SCR1_MEM_WIDTH_WORD, 32'h0000_8000, 32'hCAFE_F00D, c0);
        push_bus(1'b1, 4'b1111, 32'h0000_8000, 32'hCAFE_F00D);
        push_resp(SCR1_MEM_RESP_RDY_OK, 32'h0011_2233, c0 + 5);
        bus_phase(2, 4, 4, 32'h0, 1'b0);

        // LW 0x9000 aborted by reset in RESP: no response expected
        issue(1'b0, SCR1_MEM_WIDTH_WORD, 32'h0000_9000, 32'h0, c0);
        push_bus(1'b0, 4'b1111, 32'h0000_9000, 32'h0);
        bus_phase(1, 0, 1, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // stray grant/rvalid in IDLE
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("stray_rdata", 69'(dmem2lsu_rdata), 69'(0));
        check("stray_idle", 69'(dmem2lsu_req_ack), 69'(1));
        @(posedge clk);
        #1;

        // LH 0xA000 after reset
        issue(1'b0, SCR1_MEM_WIDTH_HWORD, 32'h0000_A000, 32'h0, c0);
        push_bus(1'b0, 4'b0011, 32'h0000_A000, 32'h0);
        push_resp(SCR1_MEM_RESP_RDY_OK, 32'h5555_ABCD, c0 + 3);
        bus_phase(1, 2, 2, 32'h5555_ABCD, 1'b0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("resp_q_drained", 69'(exp_q.size()), 69'(0));
        check("bus_q_drained", 69'(exp_bus_q.size()), 69'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
